// File: rtl/luma_frame_sched_if.sv
// Byte stream, converter and tagged-luma signals of luma_frame_sched.
// The scheduler uses the master modport; the environment around it uses slave.
interface luma_frame_sched_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] cvt_data;
    logic       cvt_valid;
    logic       cvt_rst;
    logic [7:0] luma_in;
    logic       luma_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_sof;
    logic       m_eol;
    logic       m_eof;

    modport master (
        input  s_data, s_valid, luma_in, luma_valid,
        output s_ready, cvt_data, cvt_valid, cvt_rst,
        output m_data, m_valid, m_sof, m_eol, m_eof
    );

    modport slave (
        output s_data, s_valid, luma_in, luma_valid,
        input  s_ready, cvt_data, cvt_valid, cvt_rst,
        input  m_data, m_valid, m_sof, m_eol, m_eof
    );
endinterface

// File: rtl/luma_frame_sched.sv
// Frame scheduler: gates RGB bytes into rgb2luma and tags returned luma pixels.
// Optional DRAIN watchdog enabled by defining LUMA_FRAME_SCHED_WDOG_EN.
module luma_frame_sched #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    luma_frame_sched_if.master bus
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTES = 3 * NPIX;
    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW     = $clog2(NBYTES + 1);
    localparam int PW     = $clog2(NPIX + 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
    localparam logic [PW-1:0] PIX_ALL   = PW'(NPIX);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t      state_q;
    logic [BW-1:0] byte_cnt_q;
    logic [PW-1:0] pix_cnt_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic        s_ready_q, cvt_valid_q, cvt_rst_q;
    logic [7:0]  cvt_data_q, m_data_q;
    logic        m_valid_q, m_sof_q, m_eol_q, m_eof_q;
    logic        busy_q, done_q;
    logic        take_pix_d;
`ifdef LUMA_FRAME_SCHED_WDOG_EN
    logic [3:0]  wdog_q;
    logic        err_q;
`endif

    // A returned pixel is only counted while a frame is live and not yet complete.
    always_comb begin
        take_pix_d = bus.luma_valid && (state_q == S_STREAM || state_q == S_DRAIN)
                     && (pix_cnt_q != PIX_ALL);
        x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST)
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            s_ready_q   <= 1'b0;
            cvt_valid_q <= 1'b0;
            cvt_data_q  <= '0;
            cvt_rst_q   <= 1'b1;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LUMA_FRAME_SCHED_WDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            cvt_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            cvt_valid_q <= bus.s_valid & s_ready_q;
            cvt_data_q  <= bus.s_data;
            m_valid_q   <= take_pix_d;
`ifdef LUMA_FRAME_SCHED_WDOG_EN
            err_q       <= 1'b0;
            if (state_q != S_DRAIN)
                wdog_q <= '0;
`endif
            if (take_pix_d) begin
                m_data_q  <= bus.luma_in;
                m_sof_q   <= (x_q == '0) && (y_q == '0);
                m_eol_q   <= (x_q == X_LAST);
                m_eof_q   <= (x_q == X_LAST) && (y_q == Y_LAST);
                x_q       <= x_d;
                y_q       <= y_d;
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FLUSH;
                        cvt_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    byte_cnt_q <= '0;
                    pix_cnt_q  <= '0;
                    x_q        <= '0;
                    y_q        <= '0;
                    s_ready_q  <= 1'b1;
                    state_q    <= S_STREAM;
                end
                S_STREAM: begin
                    if (bus.s_valid && s_ready_q) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == BYTE_LAST) begin
                            s_ready_q <= 1'b0;
                            state_q   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pix_cnt_q == PIX_ALL) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
`ifdef LUMA_FRAME_SCHED_WDOG_EN
                    else if (bus.luma_valid) begin
                        wdog_q <= '0;
                    end else if (wdog_q == 4'd14) begin
                        // Converter stalled: abort the frame and re-phase it.
                        wdog_q    <= 4'd15;
                        err_q     <= 1'b1;
                        cvt_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.cvt_valid = cvt_valid_q;
    assign bus.cvt_data  = cvt_data_q;
    assign bus.cvt_rst   = cvt_rst_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_sof     = m_sof_q;
    assign bus.m_eol     = m_eol_q;
    assign bus.m_eof     = m_eof_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef LUMA_FRAME_SCHED_WDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_luma_frame_sched.sv
// Scoreboard bench for luma_frame_sched with a behavioural rgb2luma converter model.
module tb_luma_frame_sched;
    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;
    localparam int NBYTES = 3 * NPIX;

    logic clk = 1'b0;
    logic rst, start, busy, done, err;
    logic spur = 1'b0, hold = 1'b0;
    logic conv_valid = 1'b0;
    logic [7:0] conv_out = '0, conv_r = '0, conv_g = '0;
    int conv_ph = 0;

    luma_frame_sched_if bus();

    luma_frame_sched #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.luma_in    = conv_out;
    assign bus.luma_valid = conv_valid | spur;

    typedef struct packed {
        logic [7:0] d;
        logic sof, eol, eof;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;
    int cvt_cnt = 0, rst_cnt = 0, done_cnt = 0, err_cnt = 0;
    bit eof_prev = 1'b0;

    function automatic logic [7:0] lumaf(input logic [7:0] r, g, b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'((s >> 8) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural rgb2luma: R,G,B phases, one luma result the edge after the blue byte.
    always @(posedge clk) begin
        if (bus.cvt_rst === 1'b1) begin
            conv_ph    <= 0;
            conv_valid <= 1'b0;
        end else begin
            conv_valid <= 1'b0;
            if (bus.cvt_valid === 1'b1) begin
                case (conv_ph)
                    0: conv_r <= bus.cvt_data;
                    1: conv_g <= bus.cvt_data;
                    default: if (!hold) begin
                        conv_out   <= lumaf(conv_r, conv_g, bus.cvt_data);
                        conv_valid <= 1'b1;
                    end
                endcase
                conv_ph <= (conv_ph == 2) ? 0 : conv_ph + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every m_valid beat and tracks side pulses.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (eof_prev)
                chk("done_after_eof", done, 1);
            else if (done)
                chk("done_without_eof", done, 0);
            eof_prev = bus.m_valid && bus.m_eof;
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", bus.m_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", bus.m_data, e.d);
                    chk("pix_tags", {bus.m_sof, bus.m_eol, bus.m_eof}, {e.sof, e.eol, e.eof});
                    $display("beat data=%0d sof=%0b eol=%0b eof=%0b", bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof);
                end
            end
            if (bus.cvt_valid) cvt_cnt++;
            if (bus.cvt_rst) rst_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end else begin
            eof_prev = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_cvt"}, {bus.cvt_valid, bus.cvt_data, bus.cvt_rst}, {1'b0, 8'd0, 1'b1});
        chk({tag, "_m_data"}, bus.m_data, 0);
        chk({tag, "_m_flags"}, {bus.m_valid, bus.m_sof, bus.m_eol, bus.m_eof}, 4'b0000);
        chk({tag, "_status"}, {busy, done, err}, 3'b000);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        guard = 0;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard == 100) chk("s_ready_timeout", guard, 0);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        if (gaps) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference: pixel k of a frame gets tags from its raster position only.
    task automatic send_bytes(input int n, input bit gaps, input bit rnd, input bit hold_last);
        logic [7:0] r, g, b, v;
        exp_t e;
        r = '0; g = '0;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 8'($urandom_range(0, 255)) : 8'd100;
            if (i % 3 == 0) r = v;
            else if (i % 3 == 1) g = v;
            else begin
                b = v;
                if (hold_last && i == NBYTES - 1) begin
                    hold = 1'b1;
                end else begin
                    e.d   = lumaf(r, g, b);
                    e.sof = (i / 3 == 0);
                    e.eol = ((i / 3) % W == W - 1);
                    e.eof = (i / 3 == NPIX - 1);
                    exp_q.push_back(e);
                end
            end
            send_byte(v, gaps && (i != n - 1));
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
    endtask

    task automatic finish_frame(output bit ok);
        chk("s_ready_after_last", bus.s_ready, 0);
        wait_done(ok);
        chk("cvt_valid_count", cvt_cnt, NBYTES);
        chk("cvt_rst_count", rst_cnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("frame end cvt_valid=%0d cvt_rst=%0d", cvt_cnt, rst_cnt);
    endtask

    task automatic pulse_start();
        cvt_cnt = 0;
        rst_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("flush_cvt_rst", bus.cvt_rst, 1);
    endtask

    initial begin
        bit ok;
        rst = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Contiguous constant-grey frame.
        pulse_start();
        send_bytes(NBYTES, 1'b0, 1'b0, 1'b0);
        finish_frame(ok);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);

        // Same frame with s_valid toggling every cycle.
        pulse_start();
        send_bytes(NBYTES, 1'b1, 1'b1, 1'b0);
        finish_frame(ok);
        @(posedge clk); #1;

        // Back-to-back: start in DONE is ignored, start in IDLE is honoured.
        pulse_start();
        send_bytes(NBYTES, 1'b0, 1'b1, 1'b0);
        finish_frame(ok);
        start = 1'b1;
        cvt_cnt = 0;
        rst_cnt = 0;
        @(posedge clk); #1;
        chk("start_in_done_ignored", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_idle_taken", busy, 1);
        send_bytes(NBYTES, 1'b0, 1'b1, 1'b0);
        finish_frame(ok);
        @(posedge clk); #1;

        // Reset after byte 10 of a frame.
        pulse_start();
        send_bytes(10, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("partial_frame_drained", exp_q.size(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("midreset");
        rst = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send_bytes(NBYTES, 1'b0, 1'b1, 1'b0);
        finish_frame(ok);
        @(posedge clk); #1;

        // Spurious luma_valid while idle.
        spur = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("idle_spurious_m_valid", bus.m_valid, 0);
        end
        spur = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send_bytes(NBYTES, 1'b0, 1'b1, 1'b0);
        finish_frame(ok);
        @(posedge clk); #1;

`ifdef LUMA_FRAME_SCHED_WDOG_EN
        begin
            int d0;
            bit seen;
            d0 = done_cnt;
            pulse_start();
            send_bytes(NBYTES, 1'b0, 1'b1, 1'b1);
            seen = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (err) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wdog_err_pulse", seen, 1);
            chk("wdog_idle", busy, 0);
            chk("wdog_cvt_rst", bus.cvt_rst, 1);
            hold = 1'b0;
            @(posedge clk); #1;
            chk("wdog_err_one_cycle", err, 0);
            chk("wdog_no_done", done_cnt - d0, 0);
            chk("wdog_scoreboard", exp_q.size(), 0);
            $display("watchdog abort err_pulses=%0d", err_cnt);
        end
`else
        chk("err_tied_low", err_cnt, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/luma_frame_sched.md
# luma_frame_sched

Frame scheduler for the grayscale front end of the Sobel pipeline. It accepts an interleaved R,G,B byte stream from the host side, gates it into the `rgb2luma` converter, and realigns the converter's colour phase at every frame start. It counts returned luma pixels against the programmed frame size and tags them with start-of-frame, end-of-line and end-of-frame markers for the downstream line buffers.

## Interface
- IMG_W, default 640: pixels per line, minimum 2.
- IMG_H, default 480: lines per frame, minimum 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low; the block is in reset while `rst`=0 at a rising edge.
- start  in  1  frame start request; sampled only in IDLE.
- s_data  in  8  upstream byte, ordered R,G,B per pixel.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  byte accepted on the edge where s_valid=1 and s_ready=1.
- cvt_data  out  8  byte to the converter's data_in.
- cvt_valid  out  1  to the converter's valid_in.
- cvt_rst  out  1  active-high reset to the converter; forces its phase back to RED.
- luma_in  in  8  converter's data_out.
- luma_valid  in  1  converter's valid_out.
- m_data  out  8  luma pixel.
- m_valid  out  1  pixel valid. There is no backpressure; the sink must accept every beat.
- m_sof, m_eol, m_eof  out  1  first pixel of frame, last pixel of line, last pixel of frame. Each is qualified by m_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse on a watchdog abort. Tied to 0 when the watchdog is compiled out.

## Operation
- State machine: IDLE, FLUSH, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 moves to FLUSH.
  - luma_valid is ignored.
- FLUSH (1 cycle):
  - cvt_rst=1.
  - Byte and pixel counters are cleared.
  - Next state is STREAM.
- STREAM:
  - s_ready=1 until 3·IMG_W·IMG_H bytes have been accepted.
  - On accepting the last byte, moves to DRAIN.
- DRAIN:
  - s_ready=0.
  - Waits until the pixel counter reaches IMG_W·IMG_H, then moves to DONE.
- DONE (1 cycle):
  - done=1.
  - Next state is IDLE.
- Byte path is registered:
  - cvt_valid <= s_valid & s_ready.
  - cvt_data <= s_data.
  - cvt_valid is 0 in every other case.
- Pixel path:
  - Counters x (0..IMG_W-1) and y (0..IMG_H-1) advance on luma_valid in STREAM or DRAIN.
  - x wraps to 0 and y increments when x=IMG_W-1.
- Output registers, updated on the same edge as the counters:
  - m_data <= luma_in.
  - m_valid <= luma_valid.
  - m_sof = (x==0 && y==0).
  - m_eol = (x==IMG_W-1).
  - m_eof = (x==IMG_W-1 && y==IMG_H-1).
- luma_valid beyond IMG_W·IMG_H pixels, or in IDLE, FLUSH or DONE, is dropped: m_valid stays 0.
- start while busy=1 is ignored.
- Counter widths are $clog2 of the respective maximum. Byte count uses $clog2(3·IMG_W·IMG_H+1) bits with no overflow.

## Timing
- Reset values:
  - State IDLE.
  - s_ready=0, cvt_valid=0, cvt_data=0, cvt_rst=1.
  - m_data=0, m_valid=0, m_sof=0, m_eol=0, m_eof=0.
  - busy=0, done=0, err=0.
  - All counters 0.
- cvt_rst is 0 outside reset and FLUSH.
- start sampled at edge 0:
  - FLUSH during cycle 1.
  - STREAM during cycle 2, with s_ready=1 from cycle 2.
- Pixel latency:
  - Blue byte handshake at edge E gives cvt_valid high at E+1.
  - The converter's luma_valid is high at E+2.
  - m_valid is high at E+3.
- DONE follows the cycle in which the final pixel is registered. done pulses together with the m_eof beat +1 cycle.
- Reset mid-frame:
  - Aborts immediately with no done pulse.
  - cvt_rst is reasserted.
  - A partially accepted pixel is discarded.
- s_valid gaps are allowed at any byte position; the converter holds its phase.

## Configuration
- LUMA_FRAME_SCHED_WDOG_EN defined:
  - A 4-bit watchdog clears on every luma_valid in DRAIN and increments otherwise.
  - When it reaches 15, the block pulses err=1, sends cvt_rst=1 for 1 cycle, and returns to IDLE without asserting done.
- Undefined:
  - DRAIN waits indefinitely.
  - err is constant 0.

## Test plan
- IMG_W=4, IMG_H=2, start pulse, 24 contiguous bytes with R=G=B=100:
  - 8 m_valid beats.
  - m_sof on beat 0; m_eol on beats 3 and 7; m_eof on beat 7.
  - done one cycle later; busy low afterwards.
- Same frame with s_valid toggled 1/0 every cycle:
  - Identical tags.
  - s_ready drops after byte 24.
  - No extra cvt_valid.
- Two back-to-back frames, with start reasserted in the DONE cycle and then in IDLE:
  - The DONE-cycle start is ignored; the IDLE start is honoured.
  - cvt_rst pulses exactly once per frame.
- rst=0 after byte 10 of a frame:
  - Next cycle shows every output at its reset value, with cvt_rst=1.
  - A following full frame produces correct tags.
- Spurious luma_valid=1 in IDLE: m_valid stays 0 and the counters are unchanged.
- With WDOG_EN, a converter model that withholds the last pixel: err pulses 15 cycles after the last luma_valid in DRAIN, done never pulses, and the block is back in IDLE the next cycle.
